// File: rtl/ctrl_fsm_gen.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/WB with a
// load/store timeout that parks the machine in ERR until run drops.
module ctrl_fsm_gen #(
    parameter int INSTR_W    = 16,
    parameter int DATA_W     = 16,
    parameter int NREG       = 8,
    parameter int LS_TIMEOUT = 15,
    parameter int CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       run,
    input  logic [INSTR_W-1:0]         d_in,
    input  logic                       ls_done,
    output logic                       en_i,
    output logic                       en_s,
    output logic                       en_c,
    output logic [1:0]                 en_ls,
    output logic                       mem_alu,
    output logic [$clog2(NREG):0]      mux_sel,
    output logic [2:0]                 alu_sel,
    output logic [DATA_W-1:0]          imm_val,
    output logic [NREG-1:0]            reg_we,
    output logic                       done,
    output logic                       busy,
    output logic                       err,
    output logic [CNT_W-1:0]           instr_cnt
);

    localparam int REG_AW = $clog2(NREG);
    localparam int IMM_W  = INSTR_W - REG_AW - 5;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_WB     = 3'd3;
    localparam logic [2:0] S_ERR    = 3'd4;

    localparam logic [7:0]       TO_MAX  = 8'(LS_TIMEOUT);
    localparam logic [7:0]       TO_ONE  = 8'd1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [NREG-1:0]  WE_ONE  = {{(NREG-1){1'b0}}, 1'b1};

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [7:0]        to_cnt;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [2:0]        op;
    logic [1:0]        ty;
    logic              is_mem;
    logic              is_imm;
    logic              is_store;

    assign rd       = d_in[INSTR_W-1 -: REG_AW];
    assign rs       = d_in[INSTR_W-REG_AW-1 -: REG_AW];
    assign op       = d_in[4:2];
    assign ty       = d_in[1:0];
    assign is_mem   = (ty == 2'b11);
    assign is_imm   = (ty == 2'b01);
    assign is_store = (d_in[2:0] == 3'b111);

    always_comb begin
        imm_val = '0;
        imm_val[IMM_W-1:0] = d_in[IMM_W+4:5];
    end

    always_comb begin
        state_nxt = S_FETCH;
        if (run) begin
            unique case (state)
                S_FETCH:  state_nxt = S_DECODE;
                S_DECODE: state_nxt = S_EXEC;
                S_EXEC: begin
                    if (!is_mem || ls_done)
                        state_nxt = S_WB;
                    else if (to_cnt == TO_MAX)
                        state_nxt = S_ERR;
                    else
                        state_nxt = S_EXEC;
                end
                S_WB:     state_nxt = S_FETCH;
                S_ERR:    state_nxt = S_ERR;
                default:  state_nxt = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_FETCH;
            to_cnt    <= '0;
            instr_cnt <= '0;
        end else begin
            state <= state_nxt;
            // Counter only survives while a memory op keeps waiting.
            if (state == S_EXEC && state_nxt == S_EXEC)
                to_cnt <= to_cnt + TO_ONE;
            else
                to_cnt <= '0;
            if (state == S_WB && run)
                instr_cnt <= instr_cnt + CNT_ONE;
        end
    end

    always_comb begin
        en_i    = 1'b0;
        en_s    = 1'b0;
        en_c    = 1'b0;
        en_ls   = 2'b00;
        mem_alu = 1'b0;
        mux_sel = '0;
        alu_sel = 3'b000;
        reg_we  = '0;
        done    = 1'b0;
        busy    = 1'b0;
        err     = 1'b0;
        unique case (state)
            S_FETCH: begin
                en_i = 1'b1;
            end
            S_DECODE: begin
                busy    = 1'b1;
                en_s    = 1'b1;
                mux_sel = {1'b0, rd};
            end
            S_EXEC: begin
                busy    = 1'b1;
                alu_sel = op;
                if (is_imm)
                    mux_sel = {1'b1, {REG_AW{1'b0}}};
                else
                    mux_sel = {1'b0, rs};
                if (is_mem)
                    en_ls = d_in[2] ? 2'b10 : 2'b01;
                else
                    en_c = 1'b1;
            end
            S_WB: begin
                busy    = 1'b1;
                done    = 1'b1;
                mem_alu = is_mem;
                if (!is_store)
                    reg_we = WE_ONE << rd;
            end
            S_ERR: begin
                err = 1'b1;
            end
            default: begin
                en_i = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_ctrl_fsm_gen.sv
// Bench for ctrl_fsm_gen: instruction-level reference model with
// directed and random programs, plus a wide-register configuration.
module tb_ctrl_fsm_gen;

    localparam int LS_TO = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [15:0] d_in;
    logic        ls_done;
    logic        en_i, en_s, en_c, mem_alu, done, busy, err;
    logic [1:0]  en_ls;
    logic [3:0]  mux_sel;
    logic [2:0]  alu_sel;
    logic [15:0] imm_val;
    logic [7:0]  reg_we;
    logic [15:0] instr_cnt;

    logic        run2;
    logic [19:0] d_in2;
    logic        en_i2, en_s2, en_c2, mem_alu2, done2, busy2, err2;
    logic [1:0]  en_ls2;
    logic [4:0]  mux_sel2;
    logic [2:0]  alu_sel2;
    logic [15:0] imm_val2;
    logic [15:0] reg_we2;
    logic [1:0]  instr_cnt2;

    int checks = 0;
    int failures = 0;
    int cnt_model = 0;

    always #5 clk = ~clk;

    ctrl_fsm_gen #(
        .INSTR_W(16), .DATA_W(16), .NREG(8),
        .LS_TIMEOUT(LS_TO), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .d_in(d_in),
        .ls_done(ls_done), .en_i(en_i), .en_s(en_s), .en_c(en_c),
        .en_ls(en_ls), .mem_alu(mem_alu), .mux_sel(mux_sel),
        .alu_sel(alu_sel), .imm_val(imm_val), .reg_we(reg_we),
        .done(done), .busy(busy), .err(err), .instr_cnt(instr_cnt)
    );

    ctrl_fsm_gen #(
        .INSTR_W(20), .DATA_W(16), .NREG(16),
        .LS_TIMEOUT(LS_TO), .CNT_W(2)
    ) dut2 (
        .clk(clk), .reset(reset), .run(run2), .d_in(d_in2),
        .ls_done(1'b0), .en_i(en_i2), .en_s(en_s2), .en_c(en_c2),
        .en_ls(en_ls2), .mem_alu(mem_alu2), .mux_sel(mux_sel2),
        .alu_sel(alu_sel2), .imm_val(imm_val2), .reg_we(reg_we2),
        .done(done2), .busy(busy2), .err(err2), .instr_cnt(instr_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
        end
    endtask

    // ph: 0 fetch, 1 decode, 2 exec, 3 writeback, 4 error
    task automatic check_phase(input string tag, input int ph, input int w);
        int rd, rs, op, ty, ctl, mux, alu, we;
        rd  = (w >> 13) % 8;
        rs  = (w >> 10) % 8;
        op  = (w >> 2) % 8;
        ty  = w % 4;
        ctl = 0; mux = 0; alu = 0; we = 0;
        case (ph)
            0: ctl = 1 << 8;
            1: begin ctl = (1 << 7) | 2; mux = rd; end
            2: begin
                ctl = 2;
                alu = op;
                mux = (ty == 1) ? 8 : rs;
                if (ty == 3) ctl |= (((w >> 2) % 2) ? 2 : 1) << 4;
                else         ctl |= 1 << 6;
            end
            3: begin
                ctl = 2 | 4 | ((ty == 3) ? 8 : 0);
                we  = (w % 8 == 7) ? 0 : (1 << rd);
            end
            default: ctl = 1;
        endcase
        chk({tag, ".ctl"}, 32'({en_i, en_s, en_c, en_ls, mem_alu,
                                done, busy, err}), 32'(ctl));
        chk({tag, ".mux"}, 32'(mux_sel), 32'(mux));
        chk({tag, ".alu"}, 32'(alu_sel), 32'(alu));
        chk({tag, ".we"}, 32'(reg_we), 32'(we));
        chk({tag, ".imm"}, 32'(imm_val), 32'((w >> 5) % 256));
        chk({tag, ".cnt"}, 32'(instr_cnt), 32'(cnt_model % 65536));
    endtask

    // k: ls_done wait cycles (>LS_TO never); abort_ph: phase dropping run
    task automatic run_instr(input int w, input int k, input int abort_ph);
        int ty;
        ty = w % 4;
        d_in = w[15:0];
        ls_done = 1'b0;
        run = (abort_ph != 0);
        #1 check_phase("fetch", 0, w);
        @(negedge clk);
        if (abort_ph == 0) return;
        run = (abort_ph != 1);
        #1 check_phase("decode", 1, w);
        @(negedge clk);
        if (abort_ph == 1) return;
        if (ty != 3) begin
            run = (abort_ph != 2);
            #1 check_phase("exec", 2, w);
            @(negedge clk);
            if (abort_ph == 2) return;
        end else begin
            for (int i = 0; i <= LS_TO; i++) begin
                ls_done = (i == k);
                run = !(abort_ph == 2 && i == 0);
                #1 check_phase("exec_mem", 2, w);
                @(negedge clk);
                if (!run) return;
                if (ls_done) break;
                if (i == LS_TO) begin
                    ls_done = 1'b0;
                    #1 check_phase("err", 4, w);
                    @(negedge clk);
                    ls_done = 1'b1;
                    #1 check_phase("err_hold", 4, w);
                    run = 1'b0;
                    #1 check_phase("err_run0", 4, w);
                    @(negedge clk);
                    ls_done = 1'b0;
                    return;
                end
            end
            ls_done = 1'b0;
        end
        run = 1'b1;
        #1 check_phase("wb", 3, w);
        @(negedge clk);
        cnt_model++;
    endtask

    initial begin
        int w, k, ab;
        reset = 1'b0; run = 1'b0; d_in = '0; ls_done = 1'b0;
        run2 = 1'b0; d_in2 = '0;
        #2 check_phase("reset", 0, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        run_instr(16'h2401, 0, -1);
        chk("imm_instr_cnt", 32'(instr_cnt), 32'd1);
        run_instr(16'h4003, 3, -1);
        run_instr(16'h6007, 0, -1);
        run_instr(16'h8013, LS_TO, -1);
        run_instr(16'hA003, 99, -1);
        run_instr(16'h2401, 0, -1);
        run_instr(16'h5B0A, 0, 2);
        run_instr(16'h5B0F, 0, 2);

        for (int n = 0; n < 40; n++) begin
            w = int'($urandom_range(0, 65535));
            if ($urandom_range(0, 2) == 0) w = w | 3;
            k = int'($urandom_range(0, LS_TO));
            if ($urandom_range(0, 7) == 0) k = 99;
            ab = -1;
            if ($urandom_range(0, 5) == 0) ab = int'($urandom_range(0, 2));
            run_instr(w, k, ab);
        end

        // asynchronous reset in the middle of a pending load
        d_in = 16'h2003; ls_done = 1'b0; run = 1'b1;
        repeat (4) @(negedge clk);
        #1 reset = 1'b0;
        cnt_model = 0;
        #1 check_phase("rst_mid", 0, 16'h2003);
        @(posedge clk);
        #1 check_phase("rst_hold", 0, 16'h2003);
        @(negedge clk);
        reset = 1'b1;
        run = 1'b0;
        @(negedge clk);

        for (int n = 1; n <= 5; n++) begin
            d_in2 = 20'((15 << 16) | (n << 12) | (n << 2));
            run2 = 1'b1;
            for (int c = 0; c < 4; c++) begin
                #1;
                if (c == 3) begin
                    chk("w16.we", 32'(reg_we2), 32'h8000);
                    chk("w16.done", 32'(done2), 32'd1);
                end
                @(negedge clk);
            end
            #1 chk("w16.cnt", 32'(instr_cnt2), 32'(n % 4));
        end
        run2 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ctrl_fsm_gen.md
CTRL_FSM_GEN -- requirements
Module: ctrl_fsm_gen

Interface
REQ-001 SHALL have parameter INSTR_W, default 16, meaning instruction width; legal values 12..32.
REQ-002 SHALL have parameter DATA_W, default 16, meaning datapath width; must satisfy DATA_W >= INSTR_W-REG_AW-5.
REQ-003 SHALL have parameter NREG, default 8, meaning register count; legal values 2, 4, 8, 16.
REQ-004 SHALL have parameter LS_TIMEOUT, default 15, meaning the maximum EXEC wait cycles for a memory operation; legal values 1..255.
REQ-005 SHALL have parameter CNT_W, default 16, meaning the width of the retired-instruction counter.
REQ-006 SHALL derive REG_AW = clog2(NREG) internally; it is not user-set.
REQ-007 SHALL have port: clk  in  1  clock, rising edge.
REQ-008 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-009 SHALL have port: run  in  1  enable; low forces FETCH at the next edge.
REQ-010 SHALL have port: d_in  in  INSTR_W  current instruction word.
REQ-011 SHALL have port: ls_done  in  1  memory operation complete.
REQ-012 SHALL have port: en_i  out  1  instruction register load.
REQ-013 SHALL have port: en_s  out  1  source-A latch.
REQ-014 SHALL have port: en_c  out  1  ALU result latch.
REQ-015 SHALL have port: en_ls  out  2  memory request: 01 = load, 10 = store.
REQ-016 SHALL have port: mem_alu  out  1  writeback source select, 1 = memory.
REQ-017 SHALL have port: mux_sel  out  REG_AW+1  bus select; MSB=1 selects imm_val, otherwise the register index.
REQ-018 SHALL have port: alu_sel  out  3  ALU opcode.
REQ-019 SHALL have port: imm_val  out  DATA_W  zero-extended immediate.
REQ-020 SHALL have port: reg_we  out  NREG  one-hot register write enable.
REQ-021 SHALL have port: done  out  1  instruction retire pulse.
REQ-022 SHALL have port: busy  out  1  not in FETCH and not in ERR.
REQ-023 SHALL have port: err  out  1  load/store timeout fault.
REQ-024 SHALL have port: instr_cnt  out  CNT_W  retired-instruction count.

Function
REQ-025 SHALL decode these instruction fields:
- rd = d_in[INSTR_W-1 -: REG_AW]
- rs = d_in[INSTR_W-REG_AW-1 -: REG_AW]
- op = d_in[4:2]
- type = d_in[1:0]: 00 = reg-reg, 01 = immediate, 11 = memory, 10 = reserved (executes as 00).
REQ-026 SHALL drive imm_val = zero-extend of d_in[INSTR_W-REG_AW-1:5] to DATA_W, combinationally at all times.
REQ-027 SHALL implement the state machine FETCH -> DECODE -> EXEC -> WB -> FETCH, plus ERR; state advances only while run=1.
REQ-028 SHALL, in FETCH, assert en_i=1.
REQ-029 SHALL, in DECODE, assert en_s=1 with mux_sel={0,rd}.
REQ-030 SHALL, in EXEC, drive alu_sel=op and mux_sel={1,0..0} if type=01, else {0,rs}.
REQ-031 SHALL, in EXEC with type!=11, assert en_c=1 and go to WB next cycle.
REQ-032 SHALL, in EXEC with type=11, hold en_ls=01 (d_in[2]=0) or 10 (d_in[2]=1) with en_c=0 each cycle until ls_done is sampled high, then go to WB.
REQ-033 SHALL count EXEC wait cycles for type=11 in a timeout counter cleared on EXEC entry.
REQ-034 SHALL go to ERR when the timeout counter equals LS_TIMEOUT with ls_done=0; ls_done=1 on that same edge wins and goes to WB.
REQ-035 SHALL, in WB, assert done=1, set mem_alu=1 if type=11, and set reg_we[rd]=1 unless d_in[2:0]=111 (store: no writeback).
REQ-036 SHALL increment instr_cnt by 1 on each edge with done=1, wrapping from all-ones to 0.
REQ-037 SHALL, in ERR, assert err=1 with all enables 0, and hold ERR until run=0 (then FETCH) or reset.
REQ-038 SHALL give latency of 4 cycles for non-memory instructions and 4+k cycles for memory instructions, where k = wait cycles before ls_done.
REQ-039 SHALL, when run=0 in any state including mid-EXEC, go to FETCH at the next edge, with outputs still decoded from the current state for that cycle; instr_cnt holds.
REQ-040 SHALL drive all outputs not listed for a state to 0.

Reset
REQ-041 SHALL, on reset=0, immediately set state=FETCH, timeout counter=0 and instr_cnt=0.
REQ-042 SHALL, during reset, hold outputs at the FETCH decode: en_i=1, all other controls 0, err=0, busy=0.
REQ-043 SHALL take effect asynchronously at any point, including a pending load/store; no done pulse follows reset.

Verification
REQ-044 SHALL verify: run=1, d_in=16'h2401 (rd=1, imm=0x20, type=01) -> EXEC mux_sel=4'b1000, imm_val=16'h0020; WB reg_we=8'h02, done=1; instr_cnt=1.
REQ-045 SHALL verify: d_in with type=11, d_in[2]=0, ls_done high after 3 cycles -> en_ls=01 held for 4 EXEC cycles; WB mem_alu=1 and reg_we[rd]=1.
REQ-046 SHALL verify: store (d_in[2:0]=111) with ls_done immediate -> en_ls=10 for 1 cycle; WB done=1, reg_we=0.
REQ-047 SHALL verify: load with ls_done never asserted, LS_TIMEOUT=15 -> err=1 after 16 EXEC cycles; run=0 -> FETCH; err=0.
REQ-048 SHALL verify: reset=0 mid-EXEC of a load -> en_i=1, en_ls=0 and instr_cnt=0 immediately, with no done.
REQ-049 SHALL verify: NREG=16, INSTR_W=20, CNT_W=2, five reg-reg instructions with rd=15 -> reg_we=16'h8000 each; instr_cnt wraps 3 -> 0 -> 1.
